rename_unit: RTL and testbench

//  Multi-slot register rename stage between decode and dispatch. Holds the speculative RAT and a circular physical-register free list.

---
 rtl/rename_unit_pkg.sv | 18 +
 rtl/rename_freelist.sv | 88 ++++++++
 rtl/rename_unit.sv | 151 +++++++++++++++
 tb/tb_rename_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rename_unit_pkg.sv
// Shared rename-stage types and default sizing.
// NUM_PREGS here is only the default; rename_unit derives its own widths from its parameter.
package rename_unit_pkg;
   localparam int ARCH_REGS           = 32;
   localparam int NUM_PREGS           = 64;
   localparam int PHYS_REGS_ADDR_SIZE = $clog2(NUM_PREGS);

   typedef logic [4:0]                     areg_t;
   typedef logic [PHYS_REGS_ADDR_SIZE-1:0] preg_t;

   typedef struct packed {
      logic  rd_v;
      preg_t prd;
      preg_t prs1;
      preg_t prs2;
      preg_t old_prd;
   } rename_slot_t;
endpackage

// File: rtl/rename_freelist.sv
// Circular physical-register free list: W-wide peek/pop at head, W-wide slot-ordered push at tail.
// With RENAME_FLUSH_EN a committed head is kept so a flush returns every speculatively popped preg.
module rename_freelist #(
   parameter  int W         = 2,
   parameter  int NUM_PREGS = 64,
   localparam int P         = $clog2(NUM_PREGS),
   localparam int DEPTH     = NUM_PREGS - 32,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [CW-1:0]         pop_cnt,
   input  logic [W-1:0]          push_v,
   input  logic [W-1:0][P-1:0]   push_prd,
`ifdef RENAME_FLUSH_EN
   input  logic                  flush,
`endif
   output logic [W-1:0][P-1:0]   peek,
   output logic [CW-1:0]         count
);
   logic [P-1:0]          mem_q [DEPTH];
   logic [AW-1:0]         head_q, tail_q;
   logic [CW-1:0]         count_q, push_cnt;
   logic [W-1:0][AW-1:0]  push_addr;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return AW'(s);
   endfunction

   always_comb begin
      push_cnt  = '0;
      push_addr = '0;
      peek      = '0;
      for (int i = 0; i < W; i++) begin
         push_addr[i] = wrap_add(tail_q, int'(push_cnt));
         peek[i]      = mem_q[wrap_add(head_q, i)];
         if (push_v[i]) push_cnt = push_cnt + 1'b1;
      end
   end

   assign count = count_q;

`ifdef RENAME_FLUSH_EN
   logic [AW-1:0] chead_q, chead_d;
   assign chead_d = wrap_add(chead_q, int'(push_cnt));
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CW'(DEPTH);
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= P'(32 + i);
`ifdef RENAME_FLUSH_EN
         chead_q <= '0;
`endif
      end else begin
         for (int i = 0; i < W; i++)
            if (push_v[i]) mem_q[push_addr[i]] <= push_prd[i];
         tail_q <= wrap_add(tail_q, int'(push_cnt));
`ifdef RENAME_FLUSH_EN
         chead_q <= chead_d;
         // Committed state always leaves exactly DEPTH pregs free.
         if (flush) begin
            head_q  <= chead_d;
            count_q <= CW'(DEPTH);
         end else begin
            head_q  <= wrap_add(head_q, int'(pop_cnt));
            count_q <= count_q + push_cnt - pop_cnt;
         end
`else
         head_q  <= wrap_add(head_q, int'(pop_cnt));
         count_q <= count_q + push_cnt - pop_cnt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n)
         assert (int'(count_q) + int'(push_cnt) <= DEPTH + int'(pop_cnt))
            else $error("rename_freelist: push into full free list");
   end
endmodule

// File: rtl/rename_unit.sv
// Rename stage: speculative RAT with intra-group bypass, 1-cycle registered output, holds while dispatch stalls.
// RENAME_FLUSH_EN adds a committed RAT and flush_i recovery; otherwise commit only recycles pregs.
module rename_unit #(
   parameter  int FRONTEND_WIDTH      = 2,
   parameter  int NUM_PREGS           = rename_unit_pkg::NUM_PREGS,
   localparam int PHYS_REGS_ADDR_SIZE = $clog2(NUM_PREGS)
) (
   input  logic                                              clk,
   input  logic                                              reset_n,
   input  logic                                              dec_valid_i,
   output logic                                              dec_ready_o,
   input  logic [FRONTEND_WIDTH-1:0]                         dec_rd_v_i,
   input  logic [FRONTEND_WIDTH-1:0]                         dec_rs1_v_i,
   input  logic [FRONTEND_WIDTH-1:0]                         dec_rs2_v_i,
   input  logic [FRONTEND_WIDTH-1:0][4:0]                    dec_rd_i,
   input  logic [FRONTEND_WIDTH-1:0][4:0]                    dec_rs1_i,
   input  logic [FRONTEND_WIDTH-1:0][4:0]                    dec_rs2_i,
   output logic                                              dis_valid_o,
   input  logic                                              dis_ready_i,
   output logic [FRONTEND_WIDTH-1:0]                         dis_rd_v_o,
   output logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] dis_prd_o,
   output logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] dis_prs1_o,
   output logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] dis_prs2_o,
   output logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] dis_old_prd_o,
   input  logic [FRONTEND_WIDTH-1:0]                         commit_v_i,
   input  logic [FRONTEND_WIDTH-1:0][4:0]                    commit_rd_i,
   input  logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] commit_prd_i,
`ifdef RENAME_FLUSH_EN
   input  logic                                              flush_i,
`endif
   input  logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0] commit_old_prd_i
);
   import rename_unit_pkg::*;

   localparam int W  = FRONTEND_WIDTH;
   localparam int P  = PHYS_REGS_ADDR_SIZE;
   localparam int CW = $clog2(NUM_PREGS - 32 + 1);

   logic [P-1:0]          rat_q [ARCH_REGS];
   logic [P-1:0]          rat_d [ARCH_REGS];
   logic [W-1:0][P-1:0]   peek, prd, prs1, prs2, old_prd;
   logic [W-1:0]          alloc;
   logic [CW-1:0]         free_count, n_alloc, pop_cnt;
   logic                  accept, flush;

`ifdef RENAME_FLUSH_EN
   assign flush = flush_i;
`else
   logic unused_commit_map;
   assign flush             = 1'b0;
   assign unused_commit_map = ^{commit_rd_i, commit_prd_i};
`endif

   assign dec_ready_o = (!dis_valid_o || dis_ready_i) && (free_count >= CW'(W)) && !flush;
   assign accept      = dec_valid_i && dec_ready_o;
   assign pop_cnt     = accept ? n_alloc : '0;

   // Later slots see earlier slots' new pregs; ascending k leaves the youngest older writer.
   always_comb begin
      int n;
      n       = 0;
      alloc   = '0;
      prd     = '0;
      prs1    = '0;
      prs2    = '0;
      old_prd = '0;
      for (int j = 0; j < W; j++) begin
         alloc[j] = dec_rd_v_i[j] && (dec_rd_i[j] != 5'd0);
         if (alloc[j]) begin
            prd[j] = peek[n];
            n      = n + 1;
         end
         if (dec_rs1_v_i[j] && dec_rs1_i[j] != 5'd0) prs1[j] = rat_q[dec_rs1_i[j]];
         if (dec_rs2_v_i[j] && dec_rs2_i[j] != 5'd0) prs2[j] = rat_q[dec_rs2_i[j]];
         if (alloc[j]) old_prd[j] = rat_q[dec_rd_i[j]];
         for (int k = 0; k < j; k++) begin
            if (alloc[k] && dec_rs1_v_i[j] && dec_rd_i[k] == dec_rs1_i[j]) prs1[j] = prd[k];
            if (alloc[k] && dec_rs2_v_i[j] && dec_rd_i[k] == dec_rs2_i[j]) prs2[j] = prd[k];
            if (alloc[k] && alloc[j] && dec_rd_i[k] == dec_rd_i[j]) old_prd[j] = prd[k];
         end
      end
      n_alloc = CW'(n);
   end

`ifdef RENAME_FLUSH_EN
   logic [P-1:0] crat_q [ARCH_REGS];
   logic [P-1:0] crat_d [ARCH_REGS];
`endif

   always_comb begin
      rat_d = rat_q;
      if (accept)
         for (int j = 0; j < W; j++)
            if (alloc[j]) rat_d[dec_rd_i[j]] = prd[j];
`ifdef RENAME_FLUSH_EN
      crat_d = crat_q;
      for (int j = 0; j < W; j++)
         if (commit_v_i[j]) crat_d[commit_rd_i[j]] = commit_prd_i[j];
      if (flush) rat_d = crat_d;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int a = 0; a < ARCH_REGS; a++) rat_q[a] <= P'(a);
`ifdef RENAME_FLUSH_EN
         for (int a = 0; a < ARCH_REGS; a++) crat_q[a] <= P'(a);
`endif
      end else begin
         rat_q <= rat_d;
`ifdef RENAME_FLUSH_EN
         crat_q <= crat_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dis_valid_o   <= 1'b0;
         dis_rd_v_o    <= '0;
         dis_prd_o     <= '0;
         dis_prs1_o    <= '0;
         dis_prs2_o    <= '0;
         dis_old_prd_o <= '0;
      end else if (flush) begin
         dis_valid_o <= 1'b0;
      end else if (accept) begin
         dis_valid_o   <= 1'b1;
         dis_rd_v_o    <= alloc;
         dis_prd_o     <= prd;
         dis_prs1_o    <= prs1;
         dis_prs2_o    <= prs2;
         dis_old_prd_o <= old_prd;
      end else if (dis_ready_i) begin
         dis_valid_o <= 1'b0;
      end
   end

   rename_freelist #(.W(W), .NUM_PREGS(NUM_PREGS)) u_freelist (
      .clk      (clk),
      .reset_n  (reset_n),
      .pop_cnt  (pop_cnt),
      .push_v   (commit_v_i),
      .push_prd (commit_old_prd_i),
`ifdef RENAME_FLUSH_EN
      .flush    (flush),
`endif
      .peek     (peek),
      .count    (free_count)
   );
endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit (W=2, 64 pregs): vector table plus stall, exhaustion and flush sequences.
module tb_rename_unit;
   logic            clk = 1'b0;
   logic            reset_n;
   logic            dec_valid_i, dec_ready_o, dis_valid_o, dis_ready_i;
   logic [1:0]      dec_rd_v_i, dec_rs1_v_i, dec_rs2_v_i, dis_rd_v_o, commit_v_i;
   logic [1:0][4:0] dec_rd_i, dec_rs1_i, dec_rs2_i, commit_rd_i;
   logic [1:0][5:0] dis_prd_o, dis_prs1_o, dis_prs2_o, dis_old_prd_o;
   logic [1:0][5:0] commit_prd_i, commit_old_prd_i;
`ifdef RENAME_FLUSH_EN
   logic            flush_i;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] rd_v;  logic [4:0] rd0,  rd1;
      logic [1:0] s1v;   logic [4:0] s1_0, s1_1;
      logic [1:0] s2v;   logic [4:0] s2_0, s2_1;
      logic [1:0] e_v;
      logic [5:0] e_prd0, e_prd1, e_s1_0, e_s1_1, e_s2_0, e_s2_1, e_old0, e_old1;
   } vec_t;

   vec_t vt [5];
   vec_t g;

   rename_unit #(.FRONTEND_WIDTH(2), .NUM_PREGS(64)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .dec_valid_i      (dec_valid_i),
      .dec_ready_o      (dec_ready_o),
      .dec_rd_v_i       (dec_rd_v_i),
      .dec_rs1_v_i      (dec_rs1_v_i),
      .dec_rs2_v_i      (dec_rs2_v_i),
      .dec_rd_i         (dec_rd_i),
      .dec_rs1_i        (dec_rs1_i),
      .dec_rs2_i        (dec_rs2_i),
      .dis_valid_o      (dis_valid_o),
      .dis_ready_i      (dis_ready_i),
      .dis_rd_v_o       (dis_rd_v_o),
      .dis_prd_o        (dis_prd_o),
      .dis_prs1_o       (dis_prs1_o),
      .dis_prs2_o       (dis_prs2_o),
      .dis_old_prd_o    (dis_old_prd_o),
      .commit_v_i       (commit_v_i),
      .commit_rd_i      (commit_rd_i),
      .commit_prd_i     (commit_prd_i),
`ifdef RENAME_FLUSH_EN
      .flush_i          (flush_i),
`endif
      .commit_old_prd_i (commit_old_prd_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      dec_rd_v_i   = v.rd_v; dec_rd_i[0]  = v.rd0;  dec_rd_i[1]  = v.rd1;
      dec_rs1_v_i  = v.s1v;  dec_rs1_i[0] = v.s1_0; dec_rs1_i[1] = v.s1_1;
      dec_rs2_v_i  = v.s2v;  dec_rs2_i[0] = v.s2_0; dec_rs2_i[1] = v.s2_1;
   endtask

   task automatic chk_out(input string tag, input vec_t v);
      chk({tag, " valid"}, 32'(dis_valid_o), 32'd1);
      chk({tag, " rd_v"},  32'(dis_rd_v_o),    32'(v.e_v));
      chk({tag, " prd"},   32'(dis_prd_o),     32'({v.e_prd1, v.e_prd0}));
      chk({tag, " prs1"},  32'(dis_prs1_o),    32'({v.e_s1_1, v.e_s1_0}));
      chk({tag, " prs2"},  32'(dis_prs2_o),    32'({v.e_s2_1, v.e_s2_0}));
      chk({tag, " old"},   32'(dis_old_prd_o), 32'({v.e_old1, v.e_old0}));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //        rd_v   rd0 rd1  s1v   s1_0 s1_1 s2v   s2_0 s2_1  e_v    prd      prs1     prs2     old
      vt[0] = '{2'b00, 9,  9,   2'b11, 5,  31,  2'b00, 3,  3,    2'b00, 0,  0,   5,  31,  0,  0,  0,  0};
      vt[1] = '{2'b11, 1,  4,   2'b11, 2,  1,   2'b11, 3,  1,    2'b11, 32, 33,  2,  32,  3,  32, 1,  4};
      vt[2] = '{2'b11, 7,  7,   2'b11, 1,  7,   2'b01, 4,  7,    2'b11, 34, 35,  32, 34,  33, 0,  7,  34};
      vt[3] = '{2'b11, 2,  0,   2'b11, 7,  1,   2'b11, 0,  4,    2'b01, 36, 0,   35, 32,  0,  33, 2,  0};
      vt[4] = '{2'b10, 5,  2,   2'b11, 2,  2,   2'b10, 0,  9,    2'b10, 0,  37,  36, 36,  0,  9,  0,  36};

      reset_n = 1'b0; dec_valid_i = 1'b0; dis_ready_i = 1'b1;
      commit_v_i = '0; commit_rd_i = '0; commit_prd_i = '0; commit_old_prd_i = '0;
`ifdef RENAME_FLUSH_EN
      flush_i = 1'b0;
`endif
      drive(vt[0]);
      #12 reset_n = 1'b1;
      @(posedge clk); #1;

      chk("reset valid", 32'(dis_valid_o), 32'd0);
      chk("reset prd",   32'(dis_prd_o),   32'd0);
      chk("reset ready", 32'(dec_ready_o), 32'd1);

      for (int i = 0; i < 5; i++) begin
         drive(vt[i]);
         dec_valid_i = 1'b1;
         #1 chk($sformatf("v%0d ready", i), 32'(dec_ready_o), 32'd1);
         @(posedge clk); #1;
         chk_out($sformatf("v%0d", i), vt[i]);
      end

      // Dispatch stall: output holds, decode blocked, nothing popped.
      g = '{2'b11, 10, 11, 2'b00, 0, 0, 2'b00, 0, 0, 2'b11, 38, 39, 0, 0, 0, 0, 10, 11};
      drive(g);
      dis_ready_i = 1'b0;
      #1 chk("stall ready", 32'(dec_ready_o), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall valid", 32'(dis_valid_o), 32'd1);
         chk("stall prd",   32'(dis_prd_o),   32'({6'd37, 6'd0}));
      end
      dis_ready_i = 1'b1;
      #1 chk("unstall ready", 32'(dec_ready_o), 32'd1);
      @(posedge clk); #1;
      chk_out("unstall", g);

      // Twelve more groups exhaust the free list.
      repeat (12) @(posedge clk);
      #1;
      chk("last prd",    32'(dis_prd_o),   32'({6'd63, 6'd62}));
      chk("empty ready", 32'(dec_ready_o), 32'd0);
      @(posedge clk); #1;
      chk("drain valid", 32'(dis_valid_o), 32'd0);

      dec_valid_i = 1'b0;
      commit_v_i = 2'b01; commit_rd_i[0] = 5'd1; commit_prd_i[0] = 6'd32; commit_old_prd_i[0] = 6'd1;
      @(posedge clk); #1;
      commit_v_i = 2'b00;
      #1 chk("one free ready", 32'(dec_ready_o), 32'd0);
      commit_v_i = 2'b01; commit_rd_i[0] = 5'd4; commit_prd_i[0] = 6'd33; commit_old_prd_i[0] = 6'd4;
      @(posedge clk); #1;
      commit_v_i = 2'b00;
      #1 chk("two free ready", 32'(dec_ready_o), 32'd1);
      g.rd0 = 5'd12; g.rd1 = 5'd13;
      drive(g);
      dec_valid_i = 1'b1;
      @(posedge clk); #1;
      dec_valid_i = 1'b0;
      chk("recycled prd", 32'(dis_prd_o), 32'({6'd4, 6'd1}));
      #1 chk("re-empty ready", 32'(dec_ready_o), 32'd0);

`ifdef RENAME_FLUSH_EN
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      dis_ready_i = 1'b1;
      dec_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         g = '{2'b11, 5'(2*i+1), 5'(2*i+2), 2'b00, 0, 0, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0};
         drive(g);
         @(posedge clk); #1;
      end
      chk("fl g3 prd", 32'(dis_prd_o), 32'({6'd37, 6'd36}));
      dec_valid_i = 1'b0; dis_ready_i = 1'b0; flush_i = 1'b1;
      commit_v_i = 2'b11;
      commit_rd_i[0] = 5'd1; commit_prd_i[0] = 6'd32; commit_old_prd_i[0] = 6'd1;
      commit_rd_i[1] = 5'd2; commit_prd_i[1] = 6'd33; commit_old_prd_i[1] = 6'd2;
      #1 chk("flush ready", 32'(dec_ready_o), 32'd0);
      @(posedge clk); #1;
      flush_i = 1'b0; commit_v_i = 2'b00; dis_ready_i = 1'b1;
      chk("flush valid", 32'(dis_valid_o), 32'd0);
      g = '{2'b11, 8, 9, 2'b11, 1, 2, 2'b11, 3, 5, 2'b11, 34, 35, 32, 33, 3, 5, 8, 9};
      drive(g);
      dec_valid_i = 1'b1;
      #1 chk("post flush ready", 32'(dec_ready_o), 32'd1);
      @(posedge clk); #1;
      dec_valid_i = 1'b0;
      chk_out("post flush", g);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
